debounce_multi: RTL and testbench

Parametrised multi-channel debouncer, successor to the single-channel debounce block. It has a built-in synchroniser per channel, so raw asynchronous inputs (buttons, switches) connect directly. Each channel holds a registered debounced level plus single-cycle rise/fall pulses, and an aggregate any-edge flag feeds interrupt or event logic. It sits between board pins and control FSMs.

---
 rtl/debounce_channel.sv | 88 ++++++++
 rtl/debounce_multi.sv | 55 +++++
 tb/tb_debounce_multi.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/debounce_channel.sv
// One debounced channel: optional synchroniser chain, stability counter,
// registered level and single-cycle rise/fall pulses.
module debounce_channel #(
  parameter int   SYNC_STAGES = 2,
  parameter int   MAX_COUNT   = 16,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic clock,
  input  logic rst_i,
  input  logic in_i,
  output logic out_o,
  output logic rise_o,
  output logic fall_o,
  output logic edge_next_o
);

  localparam int COUNTER_BITS = $clog2(MAX_COUNT);
  localparam logic [COUNTER_BITS-1:0] CntLast = COUNTER_BITS'(MAX_COUNT - 1);

  if (MAX_COUNT < 2) begin : g_bad_count
    $error("debounce_channel: MAX_COUNT must be at least 2");
  end

  logic sync_s;

  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;

    // Synchroniser flops reset to the output level so release causes no edge.
    always_ff @(posedge clock) begin
      if (rst_i) begin
        sync_q <= {SYNC_STAGES{RESET_BIT}};
      end else begin
        sync_q[0] <= in_i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[k] <= sync_q[k-1];
        end
      end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];
  end else begin : g_bypass
    assign sync_s = in_i;
  end

  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;
  logic                    out_q, out_d;
  logic                    rise_q, rise_d;
  logic                    fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    out_d  = out_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (sync_s == out_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      out_d  = sync_s;
      cnt_d  = '0;
      rise_d = sync_s;
      fall_d = ~sync_s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst_i) begin
      cnt_q  <= '0;
      out_q  <= RESET_BIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign out_o       = out_q;
  assign rise_o      = rise_q;
  assign fall_o      = fall_q;
  // Lets the top register the aggregate flag in the same cycle as the pulses.
  assign edge_next_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: NUM_CH independent channels plus a registered
// any-edge flag that coincides with the per-channel pulses.
module debounce_multi #(
  parameter int                NUM_CH      = 4,
  parameter int                MAX_COUNT   = 16,
  parameter int                SYNC_STAGES = 2,
  parameter logic [NUM_CH-1:0] RESET_VAL   = '0
) (
  input  logic              clock,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_in,
  output logic [NUM_CH-1:0] o_out,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic              o_any_edge
);

  if (NUM_CH < 1) begin : g_bad_ch
    $error("debounce_multi: NUM_CH must be at least 1");
  end
  if (MAX_COUNT < 2) begin : g_bad_count
    $error("debounce_multi: MAX_COUNT must be at least 2");
  end

  logic [NUM_CH-1:0] edge_next_s;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .MAX_COUNT   (MAX_COUNT),
      .RESET_BIT   (RESET_VAL[n])
    ) u_channel (
      .clock       (clock),
      .rst_i       (i_rst),
      .in_i        (i_in[n]),
      .out_o       (o_out[n]),
      .rise_o      (o_rise[n]),
      .fall_o      (o_fall[n]),
      .edge_next_o (edge_next_s[n])
    );
  end

  logic any_edge_q;

  always_ff @(posedge clock) begin
    if (i_rst) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= |edge_next_s;
    end
  end

  assign o_any_edge = any_edge_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: constant vector table, hand-written corner
// sequences and a randomized run against a window-based reference model.
module tb_debounce_multi;

  localparam int NCH  = 4;
  localparam int MAXC = 4;
  localparam int SYNC = 2;

  typedef struct {
    logic           rst;
    logic [NCH-1:0] in;
    logic [NCH-1:0] expOut;
    logic [NCH-1:0] expRise;
    logic [NCH-1:0] expFall;
    logic           expAny;
  } vec_t;

  logic           clock;
  logic           rstA, rstB;
  logic [NCH-1:0] inA, inB;
  logic [NCH-1:0] outA, riseA, fallA, outB, riseB, fallB;
  logic           anyA, anyB;

  int nVec = 0;
  int nErr = 0;

  debounce_multi #(
    .NUM_CH(NCH), .MAX_COUNT(MAXC), .SYNC_STAGES(SYNC), .RESET_VAL(4'b0000)
  ) dutMain (
    .clock(clock), .i_rst(rstA), .i_in(inA),
    .o_out(outA), .o_rise(riseA), .o_fall(fallA), .o_any_edge(anyA)
  );

  debounce_multi #(
    .NUM_CH(NCH), .MAX_COUNT(MAXC), .SYNC_STAGES(0), .RESET_VAL(4'b1000)
  ) dutBypass (
    .clock(clock), .i_rst(rstB), .i_in(inB),
    .o_out(outB), .o_rise(riseB), .o_fall(fallB), .o_any_edge(anyB)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference model: the level flips once the delayed input has disagreed
  // with it on each of the last MAXC edges since the previous flip or reset.
  logic [NCH-1:0] delayLine [SYNC];
  logic [NCH-1:0] winHist [$];
  int             sinceEvt [NCH];
  logic [NCH-1:0] mOut, mRise, mFall;
  logic           mAny;

  task automatic modelStep(input logic rst, input logic [NCH-1:0] in);
    logic [NCH-1:0] sNow;
    bit             allDiffer;
    mRise = '0;
    mFall = '0;
    if (rst) begin
      for (int k = 0; k < SYNC; k++) delayLine[k] = '0;
      mOut = '0;
      for (int c = 0; c < NCH; c++) sinceEvt[c] = 0;
    end else begin
      sNow = delayLine[SYNC-1];
      for (int k = SYNC-1; k > 0; k--) delayLine[k] = delayLine[k-1];
      delayLine[0] = in;
      winHist.push_back(sNow);
      if (winHist.size() > MAXC) void'(winHist.pop_front());
      for (int c = 0; c < NCH; c++) begin
        sinceEvt[c]++;
        if (sinceEvt[c] >= MAXC) begin
          allDiffer = 1'b1;
          foreach (winHist[w]) if (winHist[w][c] == mOut[c]) allDiffer = 1'b0;
          if (allDiffer) begin
            if (mOut[c]) mFall[c] = 1'b1;
            else         mRise[c] = 1'b1;
            sinceEvt[c] = 0;
          end
        end
      end
      mOut = mOut ^ (mRise | mFall);
    end
    mAny = |(mRise | mFall);
  endtask

  task automatic applyStimulus(input logic rst, input logic [NCH-1:0] in, input bit bypass);
    if (bypass) begin
      rstB = rst;
      inB  = in;
    end else begin
      rstA = rst;
      inA  = in;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name,
                             input logic [NCH-1:0] aOut, input logic [NCH-1:0] aRise,
                             input logic [NCH-1:0] aFall, input logic aAny,
                             input logic [NCH-1:0] eOut, input logic [NCH-1:0] eRise,
                             input logic [NCH-1:0] eFall, input logic eAny);
    nVec++;
    if (aOut !== eOut || aRise !== eRise || aFall !== eFall || aAny !== eAny) begin
      nErr++;
      $display("[TB] FAIL %s: got out=%b rise=%b fall=%b any=%b, want out=%b rise=%b fall=%b any=%b",
               name, aOut, aRise, aFall, aAny, eOut, eRise, eFall, eAny);
    end
  endtask

  vec_t vecs [$];

  function automatic void addVec(input logic rst, input logic [NCH-1:0] in,
                                 input logic [NCH-1:0] o, input logic [NCH-1:0] r,
                                 input logic [NCH-1:0] f, input logic a);
    vec_t v;
    v.rst = rst; v.in = in; v.expOut = o; v.expRise = r; v.expFall = f; v.expAny = a;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [NCH-1:0] curIn;
    logic           curRst;

    rstA = 1'b1; inA = '0;
    rstB = 1'b1; inB = 4'b1000;

    // Reset with toggling inputs, then the first cycle after release.
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    // Single-channel step: update on edge 6.
    for (int i = 0; i < 5; i++) addVec(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 1);
    addVec(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 0);
    // All channels rise together, then fall together.
    addVec(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 5; i++) addVec(0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1);
    addVec(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 5; i++) addVec(0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1);
    addVec(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].in, 0);
      checkOutput($sformatf("table[%0d]", i), outA, riseA, fallA, anyA,
                  vecs[i].expOut, vecs[i].expRise, vecs[i].expFall, vecs[i].expAny);
    end

    // Glitch of 3 cycles on channel 1 is ignored; a held level then lands on edge 6.
    applyStimulus(1, 4'b0000, 0);
    checkOutput("glitchReset", outA, riseA, fallA, anyA, '0, '0, '0, 0);
    for (int e = 1; e <= 8; e++) begin
      applyStimulus(0, (e <= 3) ? 4'b0010 : 4'b0000, 0);
      checkOutput($sformatf("glitch[%0d]", e), outA, riseA, fallA, anyA, '0, '0, '0, 0);
    end
    for (int e = 1; e <= 7; e++) begin
      applyStimulus(0, 4'b0010, 0);
      checkOutput($sformatf("glitchHold[%0d]", e), outA, riseA, fallA, anyA,
                  (e >= 6) ? 4'b0010 : 4'b0000, (e == 6) ? 4'b0010 : 4'b0000, '0, e == 6);
    end

    // Reset mid-count discards progress; full latency applies after release.
    applyStimulus(1, 4'b0000, 0);
    for (int e = 1; e <= 3; e++) begin
      applyStimulus(0, 4'b0100, 0);
      checkOutput($sformatf("midRstPre[%0d]", e), outA, riseA, fallA, anyA, '0, '0, '0, 0);
    end
    applyStimulus(1, 4'b0100, 0);
    checkOutput("midRstHit", outA, riseA, fallA, anyA, '0, '0, '0, 0);
    for (int r = 1; r <= 7; r++) begin
      applyStimulus(0, 4'b0100, 0);
      checkOutput($sformatf("midRstPost[%0d]", r), outA, riseA, fallA, anyA,
                  (r >= 6) ? 4'b0100 : 4'b0000, (r == 6) ? 4'b0100 : 4'b0000, '0, r == 6);
    end

    // Bypass instance: fall on edge 4, then a 2-cycle toggle never gets through.
    applyStimulus(1, 4'b1000, 1);
    checkOutput("bypassReset", outB, riseB, fallB, anyB, 4'b1000, '0, '0, 0);
    for (int e = 1; e <= 4; e++) begin
      applyStimulus(0, 4'b0000, 1);
      checkOutput($sformatf("bypassFall[%0d]", e), outB, riseB, fallB, anyB,
                  (e >= 4) ? 4'b0000 : 4'b1000, '0, (e == 4) ? 4'b1000 : 4'b0000, e == 4);
    end
    for (int t = 0; t < 12; t++) begin
      applyStimulus(0, ((t / 2) % 2 == 0) ? 4'b1000 : 4'b0000, 1);
      checkOutput($sformatf("bypassToggle[%0d]", t), outB, riseB, fallB, anyB, '0, '0, '0, 0);
    end

    // Randomized run against the reference model, with occasional resets.
    curIn = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      curRst = (cyc == 0) || ($urandom_range(0, 59) == 0);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 6) == 0) curIn[c] = ~curIn[c];
      end
      modelStep(curRst, curIn);
      applyStimulus(curRst, curIn, 0);
      checkOutput($sformatf("random[%0d]", cyc), outA, riseA, fallA, anyA,
                  mOut, mRise, mFall, mAny);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
